regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the pipelined CPU's 64-bit, 32-entry register file.
- Arbitrates between two writeback requesters:
  - A: main ALU/pipeline writeback.
  - B: long-latency unit (load/mul/div).
- Keeps a per-register busy scoreboard for in-flight B operations and drives issue-stage stall signals.
- Output is registered and feeds the register file's write enable, destination and data inputs directly.

Parameters:
XLEN, 64, data width of write data
NREG, 32, number of architectural registers (index width 5)
STARVE_LIMIT, 4, consecutive cycles B may be denied before it is promoted over A

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
a_valid  in  1  requester A has writeback pending
a_ready  out  1  A accepted this cycle
a_rd  in  5  A destination register
a_data  in  XLEN  A write data
b_valid  in  1  requester B has writeback pending
b_ready  out  1  B accepted this cycle
b_rd  in  5  B destination register
b_data  in  XLEN  B write data
issue_valid  in  1  long-latency op issuing this cycle
issue_rd  in  5  destination of issuing long-latency op
issue_ready  out  1  issue allowed (no WAW on busy rd)
rs1  in  5  issue-stage source 1
rs2  in  5  issue-stage source 2
stall  out  1  a source or the issuing rd is busy
wb_we  out  1  register file write enable
wb_rd  out  5  register file write index
wb_data  out  XLEN  register file write data

Behaviour:
- Reset (reset_n low, asynchronous):
  - wb_we=0, wb_rd=0, wb_data=0.
  - All busy bits 0; starve counter 0.
  - With reset low, a_ready, b_ready and issue_ready are all forced 0.
  - Reset during an in-flight op discards it; the scoreboard is cleared.
- Handshake:
  - A transfer occurs when valid and ready are both 1 at a rising edge.
  - a_ready and b_ready are combinational from the valids and the promotion state; at most one is 1 per cycle.
- Grant rules:
  - Only one valid: that requester is granted.
  - Both valid: A is granted unless starve_cnt == STARVE_LIMIT, in which case B is granted.
- Starve counter:
  - Increments each cycle b_valid=1 and b_ready=0, saturating at STARVE_LIMIT.
  - Clears on a B transfer or when b_valid=0.
- Latency:
  - The granted rd/data appear on wb_rd/wb_data in the next cycle.
  - wb_we=1 in that cycle only if rd != 0.
  - A transfer with rd==0 completes its handshake but produces wb_we=0.
  - No transfer: wb_we=0; wb_rd/wb_data hold their previous values.
- Scoreboard:
  - busy[issue_rd] is set on an issue transfer (issue_valid & issue_ready) when issue_rd != 0.
  - busy[b_rd] is cleared on a B transfer.
  - Set and clear on the same rd in the same cycle: set wins.
  - busy[0] is always 0.
- issue_ready = reset_n & !busy[issue_rd]. The clear from a same-cycle B transfer is not visible until the next cycle.
- stall = (rs1!=0 & busy[rs1]) | (rs2!=0 & busy[rs2]) | (issue_valid & !issue_ready).
- Protocol:
  - Requesters hold rd/data stable while valid=1 and ready=0.
  - A never targets a busy rd; the upstream stall guarantees this and the block does not check it.

Optional Feature:
- Macro: WB_PERF_CNT_EN.
- Defined: adds outputs perf_conflict [31:0] and perf_promote [31:0], both reset to 0.
  - perf_conflict increments each cycle a_valid & b_valid.
  - perf_promote increments each cycle B is granted by starvation promotion.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: reset_n=0 asserted mid-cycle with busy[5]=1 and a transfer pending -> outputs 0 immediately; after release busy[5]=0, wb_we=0.
- Single A: a_valid=1, a_rd=3, a_data=0xDEAD -> a_ready=1 same cycle; next cycle wb_we=1, wb_rd=3, wb_data=0xDEAD.
- Starvation: a_valid and b_valid held 1 continuously, STARVE_LIMIT=4 -> A granted 4 cycles, B granted on the 5th, then A resumes; perf_promote=1 if WB_PERF_CNT_EN.
- Scoreboard: issue rd=7, then rs1=7 -> stall=1; B transfer rd=7 -> stall=0 from the following cycle; a second issue rd=7 while busy -> issue_ready=0.
- Same-cycle set/clear: B transfer rd=9 plus issue transfer rd=9 in the same cycle (both issue transfer and B transfer to rd=9 complete) -> busy[9]=1 afterwards.
- x0: A transfer rd=0 -> a_ready=1, next-cycle wb_we=0; issue rd=0 -> busy unchanged, stall=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file writeback arbiter with busy scoreboard (option: WB_PERF_CNT_EN)
module regfile_wb_arbiter #(
  parameter int XLEN         = 64,
  parameter int NREG         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            stall,
`ifdef WB_PERF_CNT_EN
  output logic [31:0]     perf_conflict,
  output logic [31:0]     perf_promote,
`endif
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]   r_starve_cnt;
  logic [NREG-1:0] r_busy;
  logic            w_promote;
  logic            w_issue_xfer;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;
  logic [NREG-1:0] w_busy_nxt;

  // B wins a contested cycle only once it has been denied STARVE_LIMIT times in a row
  assign w_promote = (r_starve_cnt == CW'(STARVE_LIMIT));

  // Readies are forced low while reset is held so nothing transfers into a clearing block
  assign a_ready = reset_n & a_valid & (~b_valid | ~w_promote);
  assign b_ready = reset_n & b_valid & (~a_valid | w_promote);

  // A new long-latency op may not issue onto a register that still has one in flight
  assign issue_ready  = reset_n & ~r_busy[issue_rd];
  assign w_issue_xfer = issue_valid & issue_ready;

  assign stall = ((rs1 != 5'd0) & r_busy[rs1]) |
                 ((rs2 != 5'd0) & r_busy[rs2]) |
                 (issue_valid & ~issue_ready);

  // Clear first, then set, so a same-cycle issue to the retiring rd keeps it busy; x0 never busy
  assign w_clr_mask = b_ready ? (NREG'(1) << b_rd) : '0;
  assign w_set_mask = (w_issue_xfer && issue_rd != 5'd0) ? (NREG'(1) << issue_rd) : '0;
  assign w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & ~NREG'(1);

  // Scoreboard update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Count consecutive denied B cycles, saturating at the promotion threshold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (!b_valid || b_ready) begin
      r_starve_cnt <= '0;
    end else if (!w_promote) begin
      r_starve_cnt <= r_starve_cnt + CW'(1);
    end
  end

  // Registered write port; index/data hold when idle, writes to x0 are suppressed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_we   <= 1'b0;
      wb_rd   <= 5'd0;
      wb_data <= '0;
    end else if (a_ready) begin
      wb_we   <= (a_rd != 5'd0);
      wb_rd   <= a_rd;
      wb_data <= a_data;
    end else if (b_ready) begin
      wb_we   <= (b_rd != 5'd0);
      wb_rd   <= b_rd;
      wb_data <= b_data;
    end else begin
      wb_we   <= 1'b0;
    end
  end

`ifdef WB_PERF_CNT_EN
  logic [31:0] r_perf_conflict;
  logic [31:0] r_perf_promote;

  assign perf_conflict = r_perf_conflict;
  assign perf_promote  = r_perf_promote;

  // Contention and starvation-promotion event counters, free-running with wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_conflict <= '0;
      r_perf_promote  <= '0;
    end else begin
      if (a_valid && b_valid) begin
        r_perf_conflict <= r_perf_conflict + 32'd1;
      end
      if (a_valid && b_ready) begin
        r_perf_promote <= r_perf_promote + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  localparam int XLEN = 64;

  logic            clk;
  logic            reset_n;
  logic            a_valid;
  logic            a_ready;
  logic [4:0]      a_rd;
  logic [XLEN-1:0] a_data;
  logic            b_valid;
  logic            b_ready;
  logic [4:0]      b_rd;
  logic [XLEN-1:0] b_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_ready;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            stall;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
`ifdef WB_PERF_CNT_EN
  logic [31:0]     perf_conflict;
  logic [31:0]     perf_promote;
`endif

  int checks;
  int errors;

  regfile_wb_arbiter #(.XLEN(XLEN), .NREG(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .stall(stall),
`ifdef WB_PERF_CNT_EN
    .perf_conflict(perf_conflict), .perf_promote(perf_promote),
`endif
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; a_valid = 1'b1; a_rd = 5'd2; a_data = 64'h1;
    b_valid = 1'b1; b_rd = 5'd3; b_data = 64'h2;
    issue_valid = 1'b0; issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    #1;
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL rst_wb_we: got %b want 0", wb_we); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL rst_wb_rd: got %0d want 0", wb_rd); end
    checks++; if (wb_data !== 64'h0) begin errors++; $display("FAIL rst_wb_data: got %0h want 0", wb_data); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready: got %b want 0", a_ready); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL rst_b_ready: got %b want 0", b_ready); end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL rst_issue_ready: got %b want 0", issue_ready); end
    a_valid = 1'b0; b_valid = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    // issue rd=5 and an A write to rd=4 in the same cycle
    issue_valid = 1'b1; issue_rd = 5'd5;
    a_valid = 1'b1; a_rd = 5'd4; a_data = 64'h44;
    tick();
    issue_valid = 1'b0; a_rd = 5'd6; a_data = 64'h66; rs1 = 5'd5;
    #1;
    checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL pre_rst_wb_we: got %b want 1", wb_we); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL pre_rst_stall: got %b want 1", stall); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL pre_rst_a_ready: got %b want 1", a_ready); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL midrst_wb_we: got %b want 0", wb_we); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL midrst_wb_rd: got %0d want 0", wb_rd); end
    checks++; if (wb_data !== 64'h0) begin errors++; $display("FAIL midrst_wb_data: got %0h want 0", wb_data); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL midrst_a_ready: got %b want 0", a_ready); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %b want 0", stall); end
    a_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    issue_valid = 1'b1; issue_rd = 5'd5;
    #1;
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL postrst_wb_we: got %b want 0", wb_we); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL postrst_busy5: issue_ready got %b want 1", issue_ready); end
    issue_valid = 1'b0;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL postrst_stall: got %b want 0", stall); end
    rs1 = 5'd0;
  endtask

  task automatic test_single_a();
    a_valid = 1'b1; a_rd = 5'd3; a_data = 64'hDEAD;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL single_a_ready: got %b want 1", a_ready); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL single_b_ready: got %b want 0", b_ready); end
    tick();
    a_valid = 1'b0;
    checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL single_wb_we: got %b want 1", wb_we); end
    checks++; if (wb_rd !== 5'd3) begin errors++; $display("FAIL single_wb_rd: got %0d want 3", wb_rd); end
    checks++; if (wb_data !== 64'hDEAD) begin errors++; $display("FAIL single_wb_data: got %0h want dead", wb_data); end
    tick();
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL idle_wb_we: got %b want 0", wb_we); end
    checks++; if (wb_rd !== 5'd3) begin errors++; $display("FAIL idle_wb_rd_hold: got %0d want 3", wb_rd); end
    checks++; if (wb_data !== 64'hDEAD) begin errors++; $display("FAIL idle_wb_data_hold: got %0h want dead", wb_data); end
  endtask

  task automatic test_starvation();
    logic exp_b;
    a_valid = 1'b1; a_rd = 5'd1; a_data = 64'hA1;
    b_valid = 1'b1; b_rd = 5'd2; b_data = 64'hB2;
    for (int k = 1; k <= 7; k++) begin
      exp_b = (k == 5);
      #1;
      checks++; if (a_ready !== ~exp_b) begin errors++; $display("FAIL starve_a_ready cyc%0d: got %b want %b", k, a_ready, ~exp_b); end
      checks++; if (b_ready !== exp_b) begin errors++; $display("FAIL starve_b_ready cyc%0d: got %b want %b", k, b_ready, exp_b); end
      tick();
      checks++; if (wb_rd !== (exp_b ? 5'd2 : 5'd1)) begin errors++; $display("FAIL starve_wb_rd cyc%0d: got %0d want %0d", k, wb_rd, exp_b ? 2 : 1); end
    end
    a_valid = 1'b0;
`ifdef WB_PERF_CNT_EN
    checks++; if (perf_promote !== 32'd1) begin errors++; $display("FAIL perf_promote: got %0d want 1", perf_promote); end
    checks++; if (perf_conflict !== 32'd7) begin errors++; $display("FAIL perf_conflict: got %0d want 7", perf_conflict); end
`endif
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL b_alone_ready: got %b want 1", b_ready); end
    tick();
    b_valid = 1'b0;
    checks++; if (wb_data !== 64'hB2) begin errors++; $display("FAIL b_alone_wb_data: got %0h want b2", wb_data); end
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sb_issue_ready: got %b want 1", issue_ready); end
    tick();
    issue_valid = 1'b0; rs1 = 5'd7;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall_rs1: got %b want 1", stall); end
    rs1 = 5'd0; rs2 = 5'd7;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall_rs2: got %b want 1", stall); end
    rs2 = 5'd0; issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sb_waw_ready: got %b want 0", issue_ready); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_waw_stall: got %b want 1", stall); end
    issue_valid = 1'b0; rs1 = 5'd7;
    b_valid = 1'b1; b_rd = 5'd7; b_data = 64'h77;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL sb_b_ready: got %b want 1", b_ready); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall_same_cycle: got %b want 1", stall); end
    tick();
    b_valid = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_stall_cleared: got %b want 0", stall); end
    checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd7) begin errors++; $display("FAIL sb_b_write: got we=%b rd=%0d want we=1 rd=7", wb_we, wb_rd); end
    rs1 = 5'd0;
  endtask

  task automatic test_same_cycle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 64'h99;
    #1;
    checks++; if (issue_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL same_handshake: got issue_ready=%b b_ready=%b want 1 1", issue_ready, b_ready); end
    tick();
    issue_valid = 1'b0; b_valid = 1'b0; rs1 = 5'd9;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL same_set_wins: stall got %b want 1", stall); end
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL same_cleanup: stall got %b want 0", stall); end
    rs1 = 5'd0;
  endtask

  task automatic test_x0();
    a_valid = 1'b1; a_rd = 5'd0; a_data = 64'h55;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL x0_a_ready: got %b want 1", a_ready); end
    tick();
    a_valid = 1'b0;
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL x0_wb_we: got %b want 0", wb_we); end
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL x0_issue_ready: got %b want 1", issue_ready); end
    tick();
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL x0_busy0_set: issue_ready got %b want 1", issue_ready); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b want 0", stall); end
    issue_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_a();
    test_starvation();
    test_scoreboard();
    test_same_cycle();
    test_x0();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
